prime_sweep: RTL and testbench
==============================

PRIME_SWEEP -- requirements
Module: prime_sweep

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in ISSUE or in WAIT before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  1  request a sweep; sampled only in IDLE.
REQ-005 lo_i  input  4  first value to test; captured when start accepted.
REQ-006 hi_i  input  4  last value to test, inclusive; captured when start accepted.
REQ-007 busy_o  output  1  high in ISSUE and WAIT.
REQ-008 done_o  output  1  one-cycle pulse at sweep end, including abort.
REQ-009 err_o  output  1  registered; set on empty range or timeout; cleared on next accepted start.
REQ-010 prime_map_o  output  16  bit n = 1 when value n was tested and found prime.
REQ-011 prime_count_o  output  5  number of set bits in prime_map_o.
REQ-012 chk_en_o  output  1  request to downstream prime checker.
REQ-013 chk_data_o  output  4  value presented to checker.
REQ-014 chk_prime_i  input  1  checker result.
REQ-015 chk_valid_i  input  1  checker ready/result valid: high when idle or result ready; low while computing.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE + start_i=1 at clock edge: capture lo/hi; clear map, count and err; go to ISSUE with cur=lo, unless lo>hi.
REQ-018 IDLE + start_i=1 with lo_i>hi_i: set err_o, leave map and count cleared, go to DONE; chk_en_o never asserted.
REQ-019 ISSUE: chk_en_o=1, chk_data_o=cur; first cycle chk_valid_i=0 moves to WAIT (request accepted).
REQ-020 WAIT: chk_en_o=0, chk_data_o holds cur; first cycle chk_valid_i=1: map[cur] <= chk_prime_i, count += chk_prime_i.
REQ-021 Same cycle as REQ-020: if cur==hi go to DONE, else cur <= cur+1 and go to ISSUE.
REQ-022 cur SHALL never wrap: hi=15 ends the sweep via the cur==hi compare before any increment.
REQ-023 Timeout counter clears on every state entry and increments each cycle in ISSUE/WAIT; at TIMEOUT_CYCLES go to DONE with err_o=1, chk_en_o=0, map/count keep partial results.
REQ-024 DONE lasts exactly one cycle with done_o=1, then IDLE.
REQ-025 start_i in ISSUE, WAIT or DONE SHALL be ignored, with no effect on any state or output.
REQ-026 chk_en_o and chk_data_o SHALL be registered, glitch-free outputs.
REQ-027 prime_map_o, prime_count_o and err_o SHALL hold their values in IDLE until the next accepted start.
REQ-028 Minimum latency per value: 2 cycles; sweep of N values with an immediate-response checker: 2N+1 cycles from start to done_o.

Reset
REQ-029 rst=1 SHALL immediately force IDLE; busy_o, done_o, err_o, chk_en_o = 0; chk_data_o, prime_map_o, prime_count_o, cur, timer = 0.
REQ-030 Reset mid-sweep SHALL abort with no done_o pulse; first start after rst deasserts starts a fresh sweep.

Verification
REQ-031 lo=2, hi=2, checker model: valid drops 1 cycle after en, returns after 3 cycles -> map=0x0004, count=1, err=0, one done_o pulse.
REQ-032 lo=0, hi=15 -> map=0x28AC (2,3,5,7,11,13), count=6, err=0, chk_data_o sequence 0..15, no wrap to 0.
REQ-033 lo=6, hi=3 -> done_o pulse 1 cycle after start edge, err=1, map=0, count=0, chk_en_o never high.
REQ-034 checker holds chk_valid_i=1 forever, lo=5, hi=9 -> after 64 cycles in ISSUE: done_o, err=1, map=0, count=0.
REQ-035 lo=0, hi=15, rst pulsed while cur=7 -> all outputs zero asynchronously, no done_o; restart lo=11, hi=13 -> map=0x2800, count=2.
REQ-036 start_i pulsed in WAIT during lo=3, hi=5 sweep -> ignored, final map=0x0028, count=2, single done_o.

Source files
------------

// File: rtl/prime_sweep_if.sv
// Sweep control and prime-checker handshake bundle for prime_sweep.
// The slave side is the sweeper; the master side drives start/range and models the checker.
interface prime_sweep_if;
  logic        start_i;
  logic [3:0]  lo_i;
  logic [3:0]  hi_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] prime_map_o;
  logic [4:0]  prime_count_o;
  logic        chk_en_o;
  logic [3:0]  chk_data_o;
  logic        chk_prime_i;
  logic        chk_valid_i;

  modport slave (
    input  start_i, lo_i, hi_i, chk_prime_i, chk_valid_i,
    output busy_o, done_o, err_o, prime_map_o, prime_count_o, chk_en_o, chk_data_o
  );

  modport master (
    output start_i, lo_i, hi_i, chk_prime_i, chk_valid_i,
    input  busy_o, done_o, err_o, prime_map_o, prime_count_o, chk_en_o, chk_data_o
  );
endinterface

// File: rtl/prime_sweep.sv
// Walks cur from lo to hi through an external prime checker, building a bitmap
// and population count of the primes found; aborts with err on empty range or timeout.
module prime_sweep #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  prime_sweep_if.slave sw
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [3:0]    cur;
  logic [3:0]    hi_q;
  logic [15:0]   map_q;
  logic [4:0]    cnt_q;
  logic          err_q;
  logic          en_q;

  logic          accept;
  logic          empty;
  logic          absorb;
  logic          tmo;
  logic          busy;
  logic          done;

  assign empty = (sw.lo_i > sw.hi_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Strobes: accept = start taken, absorb = checker result consumed, tmo = abort.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    absorb   = 1'b0;
    tmo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (sw.start_i) begin
          accept   = 1'b1;
          state_nx = empty ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!sw.chk_valid_i) begin
          state_nx = S_WAIT;
        end else if (timer == TMO_LAST) begin
          tmo      = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_WAIT: begin
        if (sw.chk_valid_i) begin
          absorb   = 1'b1;
          state_nx = (cur == hi_q) ? S_DONE : S_ISSUE;
        end else if (timer == TMO_LAST) begin
          tmo      = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_ISSUE: busy = 1'b1;
      S_WAIT:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Timer restarts on every state change, so ISSUE and WAIT each get their own budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    timer <= '0;
    else if (state_nx != state) timer <= '0;
    else if (busy)              timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= '0;
      hi_q  <= '0;
      map_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      en_q <= (state_nx == S_ISSUE);
      if (accept) begin
        hi_q  <= sw.hi_i;
        map_q <= '0;
        cnt_q <= '0;
        err_q <= empty;
        if (!empty) cur <= sw.lo_i;
      end
      if (absorb) begin
        map_q[cur] <= sw.chk_prime_i;
        cnt_q      <= cnt_q + {4'b0, sw.chk_prime_i};
        // Compare before increment so hi=15 terminates without wrapping cur.
        if (cur != hi_q) cur <= cur + 4'd1;
      end
      if (tmo) err_q <= 1'b1;
    end
  end

  assign sw.busy_o        = busy;
  assign sw.done_o        = done;
  assign sw.err_o         = err_q;
  assign sw.prime_map_o   = map_q;
  assign sw.prime_count_o = cnt_q;
  assign sw.chk_en_o      = en_q;
  assign sw.chk_data_o    = cur;

endmodule

// File: tb/tb_prime_sweep.sv
// Random and directed sweeps against a range-level prime model, with a configurable
// checker model (immediate, registered with latency/hang, stuck-valid).
module tb_prime_sweep;
  localparam int TMO = 64;
  localparam int CK_IMM = 0, CK_REG = 1, CK_STUCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prime_sweep_if sw();
  prime_sweep #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .sw(sw));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] prime_mask(input int lo, input int hi);
    logic [15:0] m;
    m = '0;
    for (int v = lo; v <= hi; v++) if (is_prime(v)) m[v] = 1'b1;
    return m;
  endfunction

  // Checker model
  int         ck_mode = CK_REG;
  int         ck_lat  = 0;
  int         ck_hang = 99;
  logic       ck_clr  = 1'b0;
  logic       ck_valid_r, ck_prime_r, ck_busy;
  int         ck_cnt, ck_acc;
  logic [3:0] ck_val;

  always @(posedge clk or posedge rst) begin
    if (rst || ck_clr) begin
      ck_valid_r <= 1'b1; ck_prime_r <= 1'b0; ck_busy <= 1'b0;
      ck_cnt <= 0; ck_acc <= 0; ck_val <= '0;
    end else if (ck_busy) begin
      if (ck_acc <= ck_hang) begin
        if (ck_cnt == 0) begin
          ck_valid_r <= 1'b1;
          ck_prime_r <= is_prime(int'(ck_val));
          ck_busy    <= 1'b0;
        end else begin
          ck_cnt <= ck_cnt - 1;
        end
      end
    end else if (sw.chk_en_o && ck_valid_r) begin
      ck_valid_r <= 1'b0;
      ck_busy    <= 1'b1;
      ck_cnt     <= ck_lat;
      ck_val     <= sw.chk_data_o;
      ck_acc     <= ck_acc + 1;
    end
  end

  assign sw.chk_valid_i = (ck_mode == CK_IMM)   ? !sw.chk_en_o :
                          (ck_mode == CK_STUCK) ? 1'b1 : ck_valid_r;
  assign sw.chk_prime_i = (ck_mode == CK_IMM) ? is_prime(int'(sw.chk_data_o)) : ck_prime_r;

  // Model expectations for the current sweep (written by stimulus only)
  int          m_lo = 0, m_n = 0, m_lat = 0;
  logic [15:0] m_map = '0;
  logic [4:0]  m_cnt = '0;
  logic        m_err = 1'b0;

  // Compare-process state
  logic active = 1'b0, have_last = 1'b0, prev_en = 1'b0;
  int   cyc = 0, idx = 0, done_cnt = 0, last_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      active <= 1'b0; have_last <= 1'b0; prev_en <= 1'b0;
    end else if (!active) begin
      chk("idle_done", sw.done_o, 0);
      chk("idle_busy", sw.busy_o, 0);
      chk("idle_en", sw.chk_en_o, 0);
      if (have_last && !sw.start_i) begin
        chk("hold_map", sw.prime_map_o, m_map);
        chk("hold_cnt", sw.prime_count_o, m_cnt);
        chk("hold_err", sw.err_o, m_err);
      end
      if (sw.start_i) begin
        active <= 1'b1; cyc <= 0; idx <= 0; prev_en <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      if (sw.chk_en_o) begin
        chk("en_in_range", idx < m_n, 1);
        if (idx < m_n) chk("chk_data_seq", sw.chk_data_o, 32'(m_lo + idx));
      end
      if (prev_en && !sw.chk_en_o) idx <= idx + 1;
      prev_en <= sw.chk_en_o;
      if (sw.done_o) begin
        chk("done_map", sw.prime_map_o, m_map);
        chk("done_cnt", sw.prime_count_o, m_cnt);
        chk("done_err", sw.err_o, m_err);
        chk("done_busy", sw.busy_o, 0);
        if (m_lat > 0) chk("latency", cyc + 1, m_lat);
        active <= 1'b0; have_last <= 1'b1;
        done_cnt <= done_cnt + 1; last_cyc <= cyc + 1;
      end else begin
        chk("busy", sw.busy_o, m_n > 0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, sw.busy_o, 0);
    chk({tag, "_done"}, sw.done_o, 0);
    chk({tag, "_err"},  sw.err_o, 0);
    chk({tag, "_en"},   sw.chk_en_o, 0);
    chk({tag, "_data"}, sw.chk_data_o, 0);
    chk({tag, "_map"},  sw.prime_map_o, 0);
    chk({tag, "_cnt"},  sw.prime_count_o, 0);
  endtask

  task automatic run_sweep(input int lo, input int hi, input int mode, input int lat,
                           input int hang, input bit noise, input bit wait_done);
    int rec, d0;
    @(posedge clk); #2;
    ck_mode = mode; ck_lat = lat; ck_hang = hang; ck_clr = 1'b1;
    @(posedge clk); #2;
    ck_clr = 1'b0;
    m_lo = lo;
    m_n  = (lo <= hi) ? hi - lo + 1 : 0;
    rec  = (mode == CK_STUCK) ? 0 : (mode == CK_REG && hang < m_n) ? hang : m_n;
    m_map = (rec == 0) ? 16'h0 : prime_mask(lo, lo + rec - 1);
    m_cnt = 5'($countones(m_map));
    m_err = (m_n == 0) || (rec < m_n);
    m_lat = (m_n == 0) ? 1 : (mode == CK_STUCK) ? TMO + 1 : (mode == CK_IMM) ? 2 * m_n + 1 : 0;
    d0 = done_cnt;
    sw.start_i = 1'b1; sw.lo_i = 4'(lo); sw.hi_i = 4'(hi);
    @(posedge clk); #2;
    sw.start_i = 1'b0;
    if (wait_done) begin
      for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
        sw.lo_i    = 4'($urandom);
        sw.hi_i    = 4'($urandom);
        sw.start_i = noise && sw.busy_o && ($urandom_range(0, 2) == 0);
        @(posedge clk); #2;
      end
      sw.start_i = 1'b0;
      chk("sweep_finished", done_cnt != d0, 1);
      repeat (2) @(posedge clk);
      #2;
      chk("single_done", done_cnt - d0, 1);
    end
  endtask

  initial begin
    int lo, hi, mode, hang, d0;
    sw.start_i = 1'b0; sw.lo_i = '0; sw.hi_i = '0;
    #12;
    chk_zero("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Slow checker, single value
    run_sweep(2, 2, CK_REG, 2, 99, 0, 1);
    chk("r31_map", sw.prime_map_o, 16'h0004);
    chk("r31_cnt", sw.prime_count_o, 1);
    chk("r31_err", sw.err_o, 0);

    // Full range, immediate checker, hi=15 must not wrap
    run_sweep(0, 15, CK_IMM, 0, 99, 0, 1);
    chk("r32_map", sw.prime_map_o, 16'h28AC);
    chk("r32_cnt", sw.prime_count_o, 6);
    chk("r32_err", sw.err_o, 0);
    chk("r32_lat", last_cyc, 33);

    // Empty range
    run_sweep(6, 3, CK_REG, 0, 99, 0, 1);
    chk("r33_lat", last_cyc, 1);
    chk("r33_err", sw.err_o, 1);
    chk("r33_map", sw.prime_map_o, 0);

    // Checker never drops valid: ISSUE timeout
    run_sweep(5, 9, CK_STUCK, 0, 99, 0, 1);
    chk("r34_lat", last_cyc, TMO + 1);
    chk("r34_err", sw.err_o, 1);
    chk("r34_map", sw.prime_map_o, 0);
    chk("r34_cnt", sw.prime_count_o, 0);

    // Checker hangs on the fifth value: WAIT timeout keeps partial results
    run_sweep(0, 15, CK_REG, 1, 4, 0, 1);
    chk("hang_map", sw.prime_map_o, 16'h000C);
    chk("hang_cnt", sw.prime_count_o, 2);
    chk("hang_err", sw.err_o, 1);

    // Asynchronous reset while cur=7, then fresh sweep
    d0 = done_cnt;
    run_sweep(0, 15, CK_REG, 1, 99, 0, 0);
    for (int k = 0; k < 200 && !(sw.chk_en_o && sw.chk_data_o == 4'd7); k++) begin
      @(posedge clk); #2;
    end
    chk("r35_reached_7", sw.chk_data_o, 7);
    #1 rst = 1'b1;
    #1 chk_zero("r35_async");
    @(posedge clk); #2;
    rst = 1'b0;
    chk("r35_no_done", done_cnt, d0);
    run_sweep(11, 13, CK_REG, 2, 99, 0, 1);
    chk("r35_map", sw.prime_map_o, 16'h2800);
    chk("r35_cnt", sw.prime_count_o, 2);

    // start_i noise while busy must be ignored
    run_sweep(3, 5, CK_REG, 1, 99, 1, 1);
    chk("r36_map", sw.prime_map_o, 16'h0028);
    chk("r36_cnt", sw.prime_count_o, 2);

    for (int s = 0; s < 40; s++) begin
      lo   = $urandom_range(0, 15);
      hi   = $urandom_range(0, 15);
      mode = ($urandom_range(0, 9) == 0) ? CK_STUCK : $urandom_range(0, 1);
      hang = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 99;
      run_sweep(lo, hi, mode, $urandom_range(0, 3), hang, 1'($urandom_range(0, 1)), 1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
